// File: rtl/ask_frame_scheduler_if.sv
// Transmit-word handshake between an upstream requester and the frame scheduler.
interface ask_frame_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/ask_frame_scheduler.sv
// Frames transmit words as preamble / MSB-first data / zero guard bits and serialises
// them into a bit stream, each bit held for CLKS_PER_BIT clocks.
module ask_frame_scheduler #(
  parameter int unsigned CLKS_PER_BIT  = 1000,
  parameter int unsigned PREAMBLE_BITS = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned GUARD_BITS    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  ask_frame_scheduler_if.slave        tx,
  output logic                        key_out,
  output logic                        busy,
  output logic                        bit_tick,
  output logic                        frame_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned MaxPd = (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
  localparam int unsigned MaxBits = (MaxPd > GUARD_BITS) ? MaxPd : GUARD_BITS;
  localparam int unsigned BitW = (MaxBits > 1) ? $clog2(MaxBits) : 1;

  localparam logic [CntW-1:0] ClkLast   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] PreLast   = BitW'(PREAMBLE_BITS - 1);
  localparam logic [BitW-1:0] DataLast  = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0] GuardLast = BitW'(GUARD_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StGuard
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  key_out_q, key_out_d;
  logic                  busy_q, busy_d;
  logic                  bit_tick_q, bit_tick_d;
  logic                  frame_done_q, frame_done_d;
  logic                  tx_ready;
  logic                  last_clk;

  // Ready is combinational so a word can be taken in the very first idle cycle.
  assign tx_ready    = (state_q == StIdle) & enable & ~reset;
  assign tx.tx_ready = tx_ready;
  assign last_clk    = (clk_cnt_q == ClkLast);

  // Next-state, bit sequencing and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    key_out_d    = key_out_q;
    frame_done_d = 1'b0;

    if (state_q != StIdle) begin
      clk_cnt_d = last_clk ? '0 : clk_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        key_out_d = 1'b0;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (tx.tx_valid && tx_ready) begin
          shift_d   = tx.tx_data;
          state_d   = StPreamble;
          key_out_d = 1'b1;
        end
      end
      StPreamble: begin
        if (last_clk) begin
          if (bit_cnt_q == PreLast) begin
            state_d   = StData;
            bit_cnt_d = '0;
            key_out_d = shift_q[DATA_WIDTH-1];
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            // Next index is even (carrier on) exactly when the current one is odd.
            key_out_d = bit_cnt_q[0];
          end
        end
      end
      StData: begin
        if (last_clk) begin
          shift_d = shift_q << 1;
          if (bit_cnt_q == DataLast) begin
            state_d   = StGuard;
            bit_cnt_d = '0;
            key_out_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            key_out_d = shift_d[DATA_WIDTH-1];
          end
        end
      end
      StGuard: begin
        key_out_d = 1'b0;
        if (last_clk) begin
          if (bit_cnt_q == GuardLast) begin
            state_d      = StIdle;
            bit_cnt_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d     = (state_d != StIdle);
    bit_tick_d = (state_d != StIdle) && (clk_cnt_d == ClkLast);
  end

  // State, counters, payload and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      key_out_q    <= 1'b0;
      busy_q       <= 1'b0;
      bit_tick_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      key_out_q    <= key_out_d;
      busy_q       <= busy_d;
      bit_tick_q   <= bit_tick_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign key_out    = key_out_q;
  assign busy       = busy_q;
  assign bit_tick   = bit_tick_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/ask_frame_scheduler.md
Name: ask_frame_scheduler

Overview:
- Frames and serializes transmit words into the timed bit stream that drives the ASK keying controller's data input.
- Accepts words from an upstream requester over a valid/ready handshake.
- Each frame is: alternating preamble, then data bits (MSB first), then guard bits at zero amplitude.
- Each bit is held for a fixed number of clocks to set the symbol rate.

Parameters:
- CLKS_PER_BIT, 1000, clock cycles per transmitted bit; must be >= 2.
- PREAMBLE_BITS, 8, number of preamble bits per frame; must be >= 1.
- DATA_WIDTH, 8, payload bits per frame.
- GUARD_BITS, 2, trailing zero-amplitude bits per frame; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits acceptance of new frames; does not abort a frame in progress.
- tx_data  input  DATA_WIDTH  payload word; sampled only on handshake.
- tx_valid  input  1  requester has a word available.
- tx_ready  output  1  scheduler can accept a word this cycle.
- key_out  output  1  bit stream to the keying controller data input; 1 = carrier on.
- busy  output  1  high while a frame is in progress (any non-IDLE state).
- bit_tick  output  1  one-cycle pulse on the last cycle of every bit period.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, data shift register 0.
- All outputs are registered except tx_ready, which is combinational: tx_ready = (state==IDLE) & enable & ~reset-held.
- States: IDLE, PREAMBLE, DATA, GUARD.
- IDLE:
  - key_out = 0.
  - A handshake (tx_valid & tx_ready at rising edge N) latches tx_data into the shift register.
  - After edge N: state = PREAMBLE, key_out = 1, busy = 1, bit counter = 0, clock counter = 0.
  - tx_valid without ready: word stays pending at the requester; no state change.
- Bit timing:
  - The clock counter counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - bit_tick = 1 during the cycle the counter equals CLKS_PER_BIT-1, in non-IDLE states only.
  - key_out changes only on the edge following bit_tick, so each bit is held exactly CLKS_PER_BIT cycles.
- PREAMBLE:
  - Bit i (0-based) = 1 when i is even, 0 when i is odd.
  - After bit PREAMBLE_BITS-1 completes: go to DATA, key_out = tx_data MSB.
- DATA:
  - DATA_WIDTH bits, MSB first; the shift register shifts left once per bit.
  - After the last bit: go to GUARD, key_out = 0.
- GUARD:
  - key_out = 0 for GUARD_BITS bit periods.
  - After the last bit: state = IDLE, busy = 0, frame_done = 1 for exactly that first IDLE cycle.
- Frame length: (PREAMBLE_BITS + DATA_WIDTH + GUARD_BITS) * CLKS_PER_BIT cycles from handshake edge to busy falling.
- Back-to-back frames:
  - tx_ready is asserted in the first IDLE cycle, concurrent with frame_done.
  - A handshake there starts the next frame on the following edge.
  - Minimum inter-frame gap is one IDLE cycle with key_out = 0.
- enable deasserted mid-frame: the frame completes normally; tx_ready stays 0 while enable = 0.
- enable deasserted in IDLE: no acceptance; tx_data is ignored.
- Reset asserted mid-frame:
  - Immediate return to IDLE; key_out = 0; latched word is discarded.
  - No frame_done pulse.
  - Operation resumes on the first edge after reset deasserts.
- Counter widths: $clog2 of each bound, minimum 1 bit. No overflow is possible; counters are compared against the terminal value and then cleared.
- tx_data changes after the handshake have no effect on the frame in progress.

Test Plan (CLKS_PER_BIT=4, PREAMBLE_BITS=4, DATA_WIDTH=8, GUARD_BITS=2):
- Single frame, tx_data=8'hC5 -> key_out sequence per 4-cycle bit is 1010 11000101 00; busy high for 56 cycles; exactly one frame_done pulse; 14 bit_tick pulses.
- Back-to-back, tx_valid held high with 8'hFF then 8'h00 -> second handshake occurs in the frame_done cycle; exactly one key_out=0 IDLE cycle between frames; second payload is all zeros.
- enable dropped at cycle 10 of a frame -> frame completes unchanged; tx_ready stays 0 until enable returns; a pending tx_valid is then accepted.
- Reset pulsed at cycle 30 of a frame -> key_out, busy, bit_tick 0 in the same cycle; no frame_done; a new frame after reset starts with preamble bit 1.
- tx_data changed every cycle during a frame after the handshake with 8'h3C -> transmitted payload is 00111100.
- tx_valid low, enable high for 100 cycles -> key_out=0, busy=0, tx_ready=1, no bit_tick.
